// File: rtl/genius_input_encoder.sv
// -----------------------------------------------------------------------------
// genius_input_encoder
//
// Debounced three-button encoder for a memory game. Each button is brought
// into the clock domain through a two-flop synchronizer. A single FSM then
// accepts one clean press, emits its 2-bit code for one cycle, and refuses
// further presses until every button has been released and the release has
// been debounced.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a press or a
//                    release (2..65535)
//
// Ports
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   btn0..btn2    in   raw player buttons, active-high, asynchronous
//   enable        in   new presses are accepted only while high
//   symbol        out  code of last accepted press (00/01/10, 11 = none)
//   symbol_valid  out  one-cycle pulse when symbol is updated
//   multi_press   out  one-cycle pulse when several buttons rise together
//   busy          out  high whenever the FSM is not idle
//   press_count   out  accepted presses modulo 16
// -----------------------------------------------------------------------------
module genius_input_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn0,
    input  logic       btn1,
    input  logic       btn2,
    input  logic       enable,
    output logic [1:0] symbol,
    output logic       symbol_valid,
    output logic       multi_press,
    output logic       busy,
    output logic [3:0] press_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_WAIT_REL  = 2'd2,
        ST_DEB_REL   = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // True when exactly one bit of the vector is set.
    function automatic logic is_one_hot(input logic [2:0] b);
        return (b != 3'b000) && ((b & (b - 3'b001)) == 3'b000);
    endfunction

    // Maps a one-hot button vector to its symbol code.
    function automatic logic [1:0] encode_symbol(input logic [2:0] b);
        logic [1:0] code;
        case (b)
            3'b001:  code = 2'b00;
            3'b010:  code = 2'b01;
            3'b100:  code = 2'b10;
            default: code = 2'b11;
        endcase
        return code;
    endfunction

    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  w_b;
    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic [2:0]  r_cap;
    logic [2:0]  w_cap_next;
    logic [1:0]  r_symbol;
    logic [1:0]  w_symbol_next;
    logic        r_symbol_valid;
    logic        w_symbol_valid_next;
    logic        r_multi_press;
    logic        w_multi_press_next;
    logic        r_busy;
    logic [3:0]  r_press_count;
    logic [3:0]  w_press_count_next;

    assign w_b = r_sync2;

    // Two-flop synchronizer for the raw button inputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= {btn2, btn1, btn0};
            r_sync2 <= r_sync1;
        end
    end

    // Next-state and next-output logic for the press/release FSM.
    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_cap_next          = r_cap;
        w_symbol_next       = r_symbol;
        w_symbol_valid_next = 1'b0;
        w_multi_press_next  = 1'b0;
        w_press_count_next  = r_press_count;
        case (r_state)
            ST_IDLE: begin
                if (enable && (w_b != 3'b000)) begin
                    if (is_one_hot(w_b)) begin
                        w_cap_next   = w_b;
                        w_cnt_next   = 16'd0;
                        w_state_next = ST_DEB_PRESS;
                    end else begin
                        w_multi_press_next = 1'b1;
                        w_state_next       = ST_WAIT_REL;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DEB_PRESS: begin
                // A changed vector is treated as bounce and abandoned before
                // enable is considered.
                if (w_b != r_cap) begin
                    w_state_next = ST_IDLE;
                end else if (!enable) begin
                    w_state_next = ST_WAIT_REL;
                end else if (r_cnt == CNT_LAST) begin
                    w_symbol_next       = encode_symbol(r_cap);
                    w_symbol_valid_next = 1'b1;
                    w_press_count_next  = r_press_count + 4'd1;
                    w_state_next        = ST_WAIT_REL;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            ST_WAIT_REL: begin
                if (w_b == 3'b000) begin
                    w_cnt_next   = 16'd0;
                    w_state_next = ST_DEB_REL;
                end else begin
                    w_state_next = ST_WAIT_REL;
                end
            end
            ST_DEB_REL: begin
                if (w_b != 3'b000) begin
                    w_state_next = ST_WAIT_REL;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 16'd0;
            r_cap          <= 3'b000;
            r_symbol       <= 2'b11;
            r_symbol_valid <= 1'b0;
            r_multi_press  <= 1'b0;
            r_busy         <= 1'b0;
            r_press_count  <= 4'd0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_cap          <= w_cap_next;
            r_symbol       <= w_symbol_next;
            r_symbol_valid <= w_symbol_valid_next;
            r_multi_press  <= w_multi_press_next;
            r_busy         <= (w_state_next != ST_IDLE);
            r_press_count  <= w_press_count_next;
        end
    end

    assign symbol       = r_symbol;
    assign symbol_valid = r_symbol_valid;
    assign multi_press  = r_multi_press;
    assign busy         = r_busy;
    assign press_count  = r_press_count;

endmodule

// File: doc/genius_input_encoder.md
GENIUS_INPUT_ENCODER -- requirements
Module: genius_input_encoder

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, the number of consecutive stable cycles required to accept a press or a release; legal range 2..65535.
REQ-002 clock  input  1  single system clock, all state on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 btn0  input  1  player button 0, active-high, asynchronous to clock.
REQ-005 btn1  input  1  player button 1, active-high, asynchronous to clock.
REQ-006 btn2  input  1  player button 2, active-high, asynchronous to clock.
REQ-007 enable  input  1  game is in its input-receive phase; new presses are accepted only while high.
REQ-008 symbol  output  2  code of the last accepted press: 2'b00 = btn0, 2'b01 = btn1, 2'b10 = btn2, 2'b11 = none.
REQ-009 symbol_valid  output  1  one-cycle pulse; symbol is new and valid in that cycle.
REQ-010 multi_press  output  1  one-cycle pulse; two or more buttons were seen together in IDLE.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 press_count  output  4  number of accepted symbols, modulo 16.

Function
REQ-013 Each btn input SHALL pass through a two-flop synchronizer; the FSM SHALL use only the synchronized vector B[2:0].
REQ-014 The FSM SHALL have four states: IDLE, DEB_PRESS, WAIT_REL, DEB_REL.
REQ-015 In IDLE with enable=1 and B one-hot:
  - latch B into cap[2:0];
  - clear the 16-bit counter cnt;
  - go to DEB_PRESS.
REQ-016 In IDLE with enable=1 and two or more bits of B set:
  - pulse multi_press for one cycle;
  - go to WAIT_REL;
  - emit no symbol.
REQ-017 In IDLE with enable=0 or B=0, the FSM SHALL remain in IDLE; all pulses low.
REQ-018 In DEB_PRESS, the first matching rule SHALL apply:
  - B differs from cap: go to IDLE, no output;
  - enable=0: go to WAIT_REL, no output;
  - B equals cap and cnt<DEBOUNCE_CYCLES-1: increment cnt;
  - B equals cap and cnt=DEBOUNCE_CYCLES-1: load symbol with the code of cap, pulse symbol_valid, go to WAIT_REL.
REQ-019 Latency: edge 1 is the first rising edge that samples a press which stays stable. symbol_valid SHALL be high in the cycle following rising edge DEBOUNCE_CYCLES+3 (edge 7 for the default of 4).
REQ-020 In WAIT_REL, when B=0, the FSM SHALL clear cnt and go to DEB_REL; otherwise it stays in WAIT_REL.
REQ-021 In DEB_REL:
  - any bit of B set: return to WAIT_REL;
  - B=0 and cnt=DEBOUNCE_CYCLES-1: go to IDLE;
  - otherwise: increment cnt.
REQ-022 A held button SHALL produce exactly one symbol_valid, regardless of hold duration.
REQ-023 A press SHALL be accepted only after a full debounced release back to IDLE.
REQ-024 symbol SHALL hold its last accepted value until the next accepted press; it SHALL NOT change on multi_press or on an abort.
REQ-025 press_count SHALL increment in the same cycle as symbol_valid and wrap from 15 to 0.
REQ-026 symbol_valid and multi_press SHALL never be high in the same cycle.
REQ-027 Deasserting enable in WAIT_REL or DEB_REL SHALL NOT alter the release sequence.
REQ-028 All outputs SHALL be registered; no combinational path from any btn or enable input to any output.

Reset
REQ-029 While reset_n=0, asynchronously and regardless of clock:
  - state = IDLE;
  - symbol = 2'b11;
  - symbol_valid, multi_press and busy = 0;
  - press_count = 0;
  - cnt, cap and both synchronizer stages = 0.
REQ-030 Reset asserted mid-operation SHALL abort without emitting any pulse.
REQ-031 After reset_n rises, a button already held SHALL be treated as a new press.

Verification
REQ-032 DEBOUNCE_CYCLES=4, enable=1, btn1 held 20 cycles then released:
  - one symbol_valid, in the cycle after edge 7;
  - symbol=01, press_count=1;
  - busy high from edge 3 until 4 stable-low cycles after the synchronized release.
REQ-033 btn2 glitch high for 2 cycles, enable=1:
  - no symbol_valid;
  - symbol stays 11;
  - FSM returns to IDLE.
REQ-034 btn0 and btn2 rise in the same cycle:
  - multi_press pulses once;
  - no symbol_valid; symbol unchanged;
  - no new press accepted until both are released and debounced.
REQ-035 enable=0 while btn0 is pressed, then enable raised with btn0 still held:
  - btn0 is accepted, symbol=00;
  - enable dropped inside DEB_PRESS on a second press: no symbol, FSM goes to WAIT_REL.
REQ-036 17 clean single presses alternating btn0/btn1/btn2:
  - 17 symbol_valid pulses with matching codes;
  - press_count = 1 after the 17th, having wrapped 15 -> 0.
REQ-037 reset_n pulsed low during DEB_PRESS:
  - outputs return to reset values immediately;
  - no symbol_valid;
  - the still-held button is accepted DEBOUNCE_CYCLES+3 edges after reset release.
